lfsr_dcnto_bank: RTL and testbench

Multi-channel LFSR terminal-count timer bank. It extends the single LFSR count-to counter with parametrised width and channel count, a per-channel periodic/one-shot mode, auto-reload, a saturating terminal-event counter, and lockup-state protection. Each channel is an independent LFSR counter that runs until it matches a live compare value. The block sits beside other DW-style counter instances and serves as a low-area programmable tick/timeout source.

---
 rtl/lfsr_dcnto_bank.sv | 119 +++++++++++
 tb/tb_lfsr_dcnto_bank.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_dcnto_bank.sv
// Multi-channel LFSR terminal-count timer bank. Each channel is an independent
// XNOR Fibonacci LFSR that counts until it matches a live compare value.
module lfsr_dcnto_bank #(
    parameter int              width    = 8,
    parameter int              channels = 4,
    parameter logic [width-1:0] taps    = 8'hB8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [channels-1:0]         load,
    input  logic [channels-1:0]         cen,
    input  logic [channels-1:0]         mode,
    input  logic [channels*width-1:0]   data,
    input  logic [channels*width-1:0]   count_to,
    output logic [channels*width-1:0]   count,
    output logic [channels-1:0]         tercnt,
    output logic [channels-1:0]         done,
    output logic [channels-1:0]         lock_err,
    output logic [channels*8-1:0]       events
);

    localparam logic [width-1:0] ALL_ONES  = {width{1'b1}};
    localparam logic [width-1:0] ALL_ZEROS = {width{1'b0}};

    // XNOR feedback keeps all-zeros legal and makes all-ones the lockup state.
    function automatic logic feedback_bit(input logic [width-1:0] v);
        return ~^(v & taps);
    endfunction

    function automatic logic [width-1:0] lfsr_step(input logic [width-1:0] v);
        return {v[width-2:0], feedback_bit(v)};
    endfunction

    function automatic logic is_lockup(input logic [width-1:0] v);
        return (v == ALL_ONES);
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? 8'hFF : (v + 8'd1);
    endfunction

    for (genvar i = 0; i < channels; i++) begin : g_ch
        logic [width-1:0] count_r;
        logic [width-1:0] reload_r;
        logic             done_r;
        logic             lock_r;
        logic [7:0]       events_r;

        logic [width-1:0] data_s;
        logic [width-1:0] count_to_s;
        logic             tercnt_s;
        logic [width-1:0] count_nxt_s;
        logic [width-1:0] reload_nxt_s;
        logic             done_nxt_s;
        logic             lock_nxt_s;
        logic [7:0]       events_nxt_s;

        assign data_s     = data[i*width +: width];
        assign count_to_s = count_to[i*width +: width];
        assign tercnt_s   = (count_r == count_to_s);

        // Next-state selection: load beats terminal event beats stepping.
        always_comb begin
            count_nxt_s  = count_r;
            reload_nxt_s = reload_r;
            done_nxt_s   = done_r;
            lock_nxt_s   = lock_r;
            events_nxt_s = events_r;
            if (load[i]) begin
                done_nxt_s   = 1'b0;
                events_nxt_s = 8'd0;
                if (is_lockup(data_s)) begin
                    count_nxt_s  = ALL_ZEROS;
                    reload_nxt_s = ALL_ZEROS;
                    lock_nxt_s   = 1'b1;
                end else begin
                    count_nxt_s  = data_s;
                    reload_nxt_s = data_s;
                    lock_nxt_s   = 1'b0;
                end
            end else if (cen[i] && !done_r && tercnt_s) begin
                events_nxt_s = sat_inc(events_r);
                if (mode[i]) begin
                    count_nxt_s = reload_r;
                end else begin
                    done_nxt_s = 1'b1;
                end
            end else if (cen[i] && !done_r) begin
                count_nxt_s = lfsr_step(count_r);
            end else begin
                count_nxt_s = count_r;
            end
        end

        // Channel state registers.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                count_r  <= ALL_ZEROS;
                reload_r <= ALL_ZEROS;
                done_r   <= 1'b0;
                lock_r   <= 1'b0;
                events_r <= 8'd0;
            end else begin
                count_r  <= count_nxt_s;
                reload_r <= reload_nxt_s;
                done_r   <= done_nxt_s;
                lock_r   <= lock_nxt_s;
                events_r <= events_nxt_s;
            end
        end

        assign count[i*width +: width] = count_r;
        assign tercnt[i]               = tercnt_s;
        assign done[i]                 = done_r;
        assign lock_err[i]             = lock_r;
        assign events[i*8 +: 8]        = events_r;
    end

endmodule

// File: tb/tb_lfsr_dcnto_bank.sv
// Scoreboard bench for lfsr_dcnto_bank: the driver updates a behavioural model
// and queues expected outputs; a monitor compares after every rising edge.
module tb_lfsr_dcnto_bank;

    localparam int W  = 8;
    localparam int CH = 4;
    localparam logic [W-1:0] TAPS = 8'hB8;

    logic              clk;
    logic              reset;
    logic [CH-1:0]     load;
    logic [CH-1:0]     cen;
    logic [CH-1:0]     mode;
    logic [CH*W-1:0]   data;
    logic [CH*W-1:0]   count_to;
    logic [CH*W-1:0]   count;
    logic [CH-1:0]     tercnt;
    logic [CH-1:0]     done;
    logic [CH-1:0]     lock_err;
    logic [CH*8-1:0]   events;

    lfsr_dcnto_bank #(.width(W), .channels(CH), .taps(TAPS)) dut (
        .clk(clk), .reset(reset), .load(load), .cen(cen), .mode(mode),
        .data(data), .count_to(count_to), .count(count), .tercnt(tercnt),
        .done(done), .lock_err(lock_err), .events(events)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [CH*W-1:0] count;
        logic [CH-1:0]   tercnt;
        logic [CH-1:0]   done;
        logic [CH-1:0]   lock_err;
        logic [CH*8-1:0] events;
    } snap_t;

    snap_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state per channel
    int m_count[CH];
    int m_reload[CH];
    int m_done[CH];
    int m_lock[CH];
    int m_events[CH];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // One LFSR step from the spec rule: shift left, append 1 when the tapped
    // bits hold an even number of ones.
    function automatic int ref_step(input int v);
        int ones = 0;
        for (int b = 0; b < W; b++)
            if (TAPS[b] && ((v >> b) & 1) == 1) ones++;
        return ((v * 2) % (1 << W)) + ((ones % 2 == 0) ? 1 : 0);
    endfunction

    function automatic int cto_of(input int ch);
        logic [CH*W-1:0] t;
        t = count_to >> (ch * W);
        return int'(t[W-1:0]);
    endfunction

    function automatic int data_of(input int ch);
        logic [CH*W-1:0] t;
        t = data >> (ch * W);
        return int'(t[W-1:0]);
    endfunction

    task automatic set_data(input int ch, input int v);
        data[ch*W +: W] = v[W-1:0];
    endtask

    task automatic set_cto(input int ch, input int v);
        count_to[ch*W +: W] = v[W-1:0];
    endtask

    // Advance the model over the coming rising edge and queue what it predicts.
    task automatic step_model();
        snap_t s;
        int all_ones = (1 << W) - 1;
        for (int c = 0; c < CH; c++) begin
            if (!reset) begin
                m_count[c] = 0; m_reload[c] = 0; m_done[c] = 0; m_lock[c] = 0; m_events[c] = 0;
            end else if (load[c]) begin
                m_done[c] = 0; m_events[c] = 0;
                if (data_of(c) == all_ones) begin
                    m_count[c] = 0; m_reload[c] = 0; m_lock[c] = 1;
                end else begin
                    m_count[c] = data_of(c); m_reload[c] = data_of(c); m_lock[c] = 0;
                end
            end else if (cen[c] && m_done[c] == 0) begin
                if (m_count[c] == cto_of(c)) begin
                    if (m_events[c] < 255) m_events[c]++;
                    if (mode[c]) m_count[c] = m_reload[c];
                    else m_done[c] = 1;
                end else begin
                    m_count[c] = ref_step(m_count[c]);
                end
            end
        end
        for (int c = 0; c < CH; c++) begin
            s.count[c*W +: W]  = m_count[c][W-1:0];
            s.tercnt[c]        = (m_count[c] == cto_of(c));
            s.done[c]          = m_done[c][0];
            s.lock_err[c]      = m_lock[c][0];
            s.events[c*8 +: 8] = m_events[c][7:0];
        end
        exp_q.push_back(s);
    endtask

    task automatic cycle();
        step_model();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        #1;
        chk("async_rst_count", 64'(count), 64'd0);
        chk("async_rst_events", 64'(events), 64'd0);
        chk("async_rst_flags", 64'({done, lock_err}), 64'd0);
        load = '0;
        cen  = '0;
        cycle();
        reset = 1'b1;
    endtask

    // Monitor: compare DUT outputs with the oldest queued prediction.
    always begin
        snap_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("sb_count", 64'(count), 64'(e.count));
            chk("sb_tercnt", 64'(tercnt), 64'(e.tercnt));
            chk("sb_done", 64'(done), 64'(e.done));
            chk("sb_lock_err", 64'(lock_err), 64'(e.lock_err));
            chk("sb_events", 64'(events), 64'(e.events));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] seq [6];
        int r;
        int v;
        seq[0] = 8'h00; seq[1] = 8'h01; seq[2] = 8'h03;
        seq[3] = 8'h07; seq[4] = 8'h0F; seq[5] = 8'h1E;

        reset = 1'b0; load = '0; cen = '0; mode = '0; data = '0; count_to = '0;
        for (int c = 0; c < CH; c++) begin
            m_count[c] = 0; m_reload[c] = 0; m_done[c] = 0; m_lock[c] = 0; m_events[c] = 0;
        end
        set_cto(0, 8'h55);
        @(negedge clk);
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_tercnt", 64'(tercnt), 64'(4'b1110));
        cycle();
        cycle();
        reset = 1'b1;

        // Sequence from reset
        cen[0] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            chk("seq_count", 64'(count[7:0]), 64'(seq[k]));
            chk("seq_tercnt", 64'(tercnt[0]), 64'd0);
            cycle();
        end

        // Periodic, period 4
        apply_reset();
        mode[0] = 1'b1; set_cto(0, 8'h07); cen[0] = 1'b1;
        for (int k = 0; k < 3; k++) cycle();
        chk("per_count07", 64'(count[7:0]), 64'h07);
        chk("per_tercnt", 64'(tercnt[0]), 64'd1);
        cycle();
        chk("per_reload", 64'(count[7:0]), 64'h00);
        chk("per_events1", 64'(events[7:0]), 64'd1);
        for (int k = 0; k < 8; k++) cycle();
        chk("per_events3", 64'(events[7:0]), 64'd3);

        // One-shot
        apply_reset();
        mode[0] = 1'b0; set_cto(0, 8'h07); cen[0] = 1'b1;
        for (int k = 0; k < 6; k++) cycle();
        chk("os_count", 64'(count[7:0]), 64'h07);
        chk("os_done", 64'(done[0]), 64'd1);
        chk("os_events", 64'(events[7:0]), 64'd1);
        chk("os_tercnt", 64'(tercnt[0]), 64'd1);
        load[0] = 1'b1; set_data(0, 8'h03);
        cycle();
        load[0] = 1'b0; cen[0] = 1'b0;
        chk("os_reload_count", 64'(count[7:0]), 64'h03);
        chk("os_reload_done", 64'(done[0]), 64'd0);
        chk("os_reload_events", 64'(events[7:0]), 64'd0);

        // Lockup load
        load[0] = 1'b1; set_data(0, 8'hFF);
        cycle();
        chk("lock_count", 64'(count[7:0]), 64'h00);
        chk("lock_err", 64'(lock_err[0]), 64'd1);
        set_data(0, 8'h10);
        cycle();
        load[0] = 1'b0;
        chk("lock_clear", 64'(lock_err[0]), 64'd0);
        chk("lock_load10", 64'(count[7:0]), 64'h10);

        // Load against a live match, then saturation
        mode[0] = 1'b1; set_cto(0, 8'h07); load[0] = 1'b1; set_data(0, 8'h07);
        cycle();
        cen[0] = 1'b1;
        cycle();
        chk("load_wins_events", 64'(events[7:0]), 64'd0);
        load[0] = 1'b0;
        for (int k = 0; k < 300; k++) cycle();
        chk("sat_events", 64'(events[7:0]), 64'd255);
        chk("sat_count", 64'(count[7:0]), 64'h07);

        // Independent channels under random traffic with a mid-run reset
        apply_reset();
        for (int c = 0; c < CH; c++) begin
            set_data(c, $urandom_range(0, 254));
            set_cto(c, 8'hFF);
        end
        load = '1; mode = 4'b0101;
        cycle();
        load = '0; cen = '1;
        for (int c = 0; c < CH; c++) begin
            v = m_reload[c];
            for (int k = 0; k < c + 2; k++) v = ref_step(v);
            set_cto(c, v);
        end
        for (int n = 0; n < 400; n++) begin
            if (n == 200) apply_reset();
            for (int c = 0; c < CH; c++) begin
                load[c] = ($urandom_range(0, 15) == 0);
                cen[c]  = ($urandom_range(0, 7) != 0);
                if ($urandom_range(0, 31) == 0) mode[c] = ~mode[c];
                if (load[c]) begin
                    r = ($urandom_range(0, 9) == 0) ? 255 : $urandom_range(0, 254);
                    set_data(c, r);
                    v = (r == 255) ? 0 : r;
                    for (int k = 0; k < $urandom_range(1, 6); k++) v = ref_step(v);
                    set_cto(c, ($urandom_range(0, 7) == 0) ? 255 : v);
                end
            end
            cycle();
        end
        load = '0; cen = '0;
        @(posedge clk);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
